// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg: shared state encoding, sizing constants and round-robin search helper
package rr_arbiter_4_pkg;
  typedef enum logic {IDLE, OWN} state_e;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  // returns {found, index}; scans from p upward so the lowest offset from p wins
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r, input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] k;
    rr_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = p + SEL_W'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction
endpackage

// File: rtl/mux_4to1.sv
// mux_4to1: plain 4:1 single-bit multiplexer
module mux_4to1 (
  input  logic [3:0] data_i,
  input  logic [1:0] sel_i,
  output logic       y_o
);
  assign y_o = data_i[sel_i];
endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with hold limit, driving a shared data mux
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] select,
  output logic             valid,
  output logic             out
);
  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q;
  logic [N_REQ-1:0] others;
  logic [SEL_W:0]   win;
  logic             hold;
  logic             mux_y;

  // gnt_q is zero in IDLE, so masking the owner serves both states
  assign others = req & ~gnt_q;
  assign win    = rr_pick(others, ptr_q);
  assign hold   = (state_q == OWN) && req[sel_q] && !((cnt_q == CNT_MAX) && (|others));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (hold) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (win[SEL_W]) begin
      state_d = OWN;
      sel_d   = win[SEL_W-1:0];
      gnt_d   = N_REQ'(1) << win[SEL_W-1:0];
      ptr_d   = win[SEL_W-1:0] + 1'b1;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == OWN);
    end
  end

  mux_4to1 u_mux (
    .data_i (data_in),
    .sel_i  (sel_q),
    .y_o    (mux_y)
  );

  assign gnt    = gnt_q;
  assign select = sel_q;
  assign valid  = valid_q;
  assign out    = valid_q & mux_y;
endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles per owner when another requester is pending (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: req  input  4  request per requester; bit i = requester i; level-sensitive.
REQ-005 Port: data_in  input  4  one data bit per requester; bit i = requester i's data.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 Port: select  output  2  registered mux select equal to owner index; drives shared 4:1 mux.
REQ-008 Port: valid  output  1  registered; high iff gnt non-zero.
REQ-009 Port: out  output  1  shared mux output data_in[select], forced 0 when valid low.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and OWN (exactly one owner).
REQ-011 In IDLE with req != 0, the block SHALL select a winner and enter OWN next edge; gnt/select/valid SHALL reflect the winner one cycle after req is sampled.
REQ-012 Winner selection SHALL be round-robin: search starts at pointer ptr (2 bits), increments mod 4, first set req bit wins.
REQ-013 On every grant to index k, ptr SHALL update to (k+1) mod 4.
REQ-014 In OWN, the owner SHALL keep the grant while req[owner] stays high, subject to REQ-016.
REQ-015 In OWN, when req[owner] is low at an edge: if any other req bit is set, the next winner SHALL be granted on that same edge (no idle bubble); otherwise the block SHALL return to IDLE with gnt=0.
REQ-016 A hold counter SHALL count owner cycles from 0; when count = MAX_HOLD-1 and any other req bit is set, the owner SHALL be pre-empted and the round-robin winner granted on that edge.
REQ-017 If count reaches MAX_HOLD-1 and no other request is pending, the grant SHALL continue and count SHALL saturate at MAX_HOLD-1.
REQ-018 The counter SHALL reset to 0 on every new grant, including handover.
REQ-019 gnt SHALL never have more than one bit set; select SHALL hold its last value while valid is low.
REQ-020 out SHALL be combinational from data_in and the registered select, no added latency.
REQ-021 Requests arriving or dropping in the same cycle as a handover SHALL be evaluated using the sampled req of that cycle only.

Reset
REQ-022 On rst high, asynchronously: state=IDLE, gnt=0000, select=00, valid=0, ptr=0, count=0; out SHALL read 0.
REQ-023 Reset mid-ownership SHALL drop the grant immediately; after deassertion arbitration restarts from ptr=0.
REQ-024 First rising edge after rst deasserts SHALL sample req normally.

Structure
REQ-025 Shared package SHALL hold the state enum (IDLE, OWN), the requester count constant (4) and the select width constant (2).
REQ-026 The data path SHALL instantiate the existing 4:1 mux module (mux_4to1) as its single sub-module, fed by data_in[0..3] and select.

Verification
REQ-027 Reset then req=0100 -> one cycle later gnt=0100, select=10, valid=1, out=data_in[2]; ptr=3.
REQ-028 req=1111 held continuously, MAX_HOLD=8 -> grants rotate 0,1,2,3,0 each lasting exactly 8 cycles, no gap cycles.
REQ-029 Owner 1 drops req while req=1001 pending, ptr=2 -> next edge gnt=1000, select=11; count restarts at 0.
REQ-030 Single requester req=0010 held for 20 cycles -> gnt=0010 throughout, count saturates at 7, no drop.
REQ-031 rst asserted mid-grant (gnt=0100) -> gnt=0000, valid=0, out=0 without waiting for clk; after release with req=0101 -> gnt=0001.
REQ-032 All cycles, random req -> assert gnt one-hot-or-zero, valid==(gnt!=0), select matches gnt index whenever valid.
